// File: rtl/fifo_rd_stream_pkg.sv
// ============================================================================
// fifo_stream_pkg : shared occupancy encoding and packet framing helper
// Revision 1.0
// ============================================================================
`default_nettype none

package fifo_stream_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  function automatic logic is_last(input int unsigned beat, input int unsigned len);
    return (beat == (len - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_rd_stream_if.sv
// ============================================================================
// fifo_rd_stream_if : FIFO read port plus downstream valid/ready stream
// Revision 1.0
// ============================================================================
`default_nettype none

interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 3
);
  logic                  fifo_rempty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_ren;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic [1:0]            occupancy;
  logic [CNT_WIDTH-1:0]  beat_cnt;

  modport master (
    input  fifo_rempty, fifo_rdata, m_ready,
    output fifo_ren, m_valid, m_data, m_last, occupancy, beat_cnt
  );

  modport slave (
    output fifo_rempty, fifo_rdata, m_ready,
    input  fifo_ren, m_valid, m_data, m_last, occupancy, beat_cnt
  );
endinterface

`default_nettype wire

// File: rtl/fifo_rd_stream_pkt_beat_counter.sv
// ============================================================================
// pkt_beat_counter : counts accepted beats modulo PKT_LEN, flags the last beat
// Revision 1.0
// ============================================================================
`default_nettype none

module pkt_beat_counter
  import fifo_stream_pkg::*;
#(
  parameter int PKT_LEN   = 4,
  parameter int CNT_WIDTH = $clog2(PKT_LEN + 1)
) (
  input  wire logic                 clk,
  input  wire logic                 reset_n,
  input  wire logic                 clr,
  input  wire logic                 inc,
  output logic      [CNT_WIDTH-1:0] beat_cnt,
  output logic                      at_last
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  assign at_last  = is_last(32'(cnt_q), PKT_LEN);
  assign beat_cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = at_last ? '0 : CNT_WIDTH'(cnt_q + 1'b1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fifo_rd_stream.sv
// ============================================================================
// fifo_rd_stream : async-FIFO read adapter with 2-entry registered skid buffer
//                  and fixed-length packet framing on the output stream
// Revision 1.0
// ============================================================================
`default_nettype none

module fifo_rd_stream
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4,
  parameter int CNT_WIDTH  = $clog2(PKT_LEN + 1)
) (
  input  wire logic     clk,
  input  wire logic     reset_n,
  input  wire logic     flush,
  fifo_rd_stream_if.master bus
);

  occ_t                  occ_q;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic                  pop;
  logic                  fill;
  logic                  at_last;

  assign bus.m_valid   = (occ_q != OCC_EMPTY);
  assign pop           = bus.m_valid & bus.m_ready;
  // Gated by reset_n so the FIFO is never popped while this side is held in reset.
  assign fill          = reset_n & ~flush & ~bus.fifo_rempty & ((occ_q != OCC_TWO) | pop);
  assign bus.fifo_ren  = fill;
  assign bus.m_data    = head_q;
  assign bus.m_last    = bus.m_valid & at_last;
  assign bus.occupancy = occ_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else if (flush) begin
      occ_q <= OCC_EMPTY;
    end else begin
      unique case (occ_q)
        OCC_EMPTY: begin
          if (fill) begin
            head_q <= bus.fifo_rdata;
            occ_q  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (fill && !pop) begin
            tail_q <= bus.fifo_rdata;
            occ_q  <= OCC_TWO;
          end else if (pop && !fill) begin
            occ_q <= OCC_EMPTY;
          end else if (pop && fill) begin
            head_q <= bus.fifo_rdata;
          end
        end
        OCC_TWO: begin
          if (pop) begin
            head_q <= tail_q;
            if (fill) begin
              tail_q <= bus.fifo_rdata;
            end else begin
              occ_q <= OCC_ONE;
            end
          end
        end
        default: begin
          occ_q <= OCC_EMPTY;
        end
      endcase
    end
  end

  pkt_beat_counter #(
    .PKT_LEN   (PKT_LEN),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_beat_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (flush),
    .inc      (pop),
    .beat_cnt (bus.beat_cnt),
    .at_last  (at_last)
  );

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
// ============================================================================
// tb_fifo_rd_stream : directed stimulus against a registered-empty FIFO model,
//                     with a queue scoreboard checked by an output monitor
// ============================================================================
`default_nettype none

module tb_fifo_rd_stream;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic flush   = 1'b0;

  fifo_rd_stream_if #(.DATA_WIDTH(8), .CNT_WIDTH(3)) bus();

  fifo_rd_stream #(.DATA_WIDTH(8), .PKT_LEN(4), .CNT_WIDTH(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // FIFO model: combinational read data, registered empty flag
  logic [7:0] mem [0:63];
  int         wptr = 0;
  int         rptr = 0;
  logic       rempty_q = 1'b1;

  assign bus.fifo_rempty = rempty_q;
  assign bus.fifo_rdata  = mem[rptr & 63];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rptr     <= wptr;
      rempty_q <= 1'b1;
    end else begin
      if (bus.fifo_ren) rptr <= rptr + 1;
      rempty_q <= (wptr == (rptr + (bus.fifo_ren ? 1 : 0)));
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard
  logic       prev_stall = 1'b0;
  logic       prev_flush = 1'b0;
  logic [7:0] prev_data  = '0;
  logic       prev_last  = 1'b0;

  always @(negedge clk) begin
    logic [8:0] e;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      chk("ren_while_empty", {31'd0, bus.fifo_ren & bus.fifo_rempty}, 32'd0);
      chk("occ_le_2", {31'd0, bus.occupancy <= 2'd2}, 32'd1);
      if (prev_stall && !prev_flush) begin
        chk("hold_valid", {31'd0, bus.m_valid}, 32'd1);
        chk("hold_data", {24'd0, bus.m_data}, {24'd0, prev_data});
        chk("hold_last", {31'd0, bus.m_last}, {31'd0, prev_last});
      end
      if (bus.m_valid && bus.m_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got 0x%0h expected no beat at %0t", bus.m_data, $time);
        end else begin
          e = exp_q.pop_front();
          n_tests--;
          chk("sb_data", {24'd0, bus.m_data}, {24'd0, e[7:0]});
          chk("sb_last", {31'd0, bus.m_last}, {31'd0, e[8]});
        end
      end
      prev_stall = bus.m_valid & ~bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
      prev_flush = flush;
    end
  end

  // Stimulus helpers
  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_write(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[(wptr + i) & 63] = base + 8'(i);
    end
    wptr = wptr + n;
  endtask

  // Pushes expected beats base..base+n-1; every 4th beat from first_beat closes a packet.
  task automatic expect_beats(input logic [7:0] base, input int n, input int first_beat);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(((first_beat + i) % 4) == 3), base + 8'(i)});
    end
  endtask

  int o_ren_cnt, o_ren_first, o_ren_last;
  int o_pop_cnt, o_pop_first, o_pop_last;

  task automatic observe(input int n);
    o_ren_cnt = 0; o_ren_first = -1; o_ren_last = -1;
    o_pop_cnt = 0; o_pop_first = -1; o_pop_last = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      if (bus.fifo_ren) begin
        o_ren_cnt++;
        if (o_ren_first < 0) o_ren_first = i;
        o_ren_last = i;
      end
      if (bus.m_valid && bus.m_ready) begin
        o_pop_cnt++;
        if (o_pop_first < 0) o_pop_first = i;
        o_pop_last = i;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.m_ready = 1'b0;
    #1;
    chk("rst_occ", {30'd0, bus.occupancy}, 32'd0);
    chk("rst_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("rst_last", {31'd0, bus.m_last}, 32'd0);
    chk("rst_beat", {29'd0, bus.beat_cnt}, 32'd0);
    chk("rst_ren", {31'd0, bus.fifo_ren}, 32'd0);
    chk("rst_data", {24'd0, bus.m_data}, 32'd0);
    drive_edge();
    drive_edge();
    reset_n = 1'b1;
    drive_edge();

    // Full-throughput burst
    bus.m_ready = 1'b1;
    fifo_write(8'h10, 8);
    expect_beats(8'h10, 8, 0);
    observe(12);
    chk("t1_ren_cnt", o_ren_cnt, 8);
    chk("t1_ren_span", o_ren_last - o_ren_first + 1, 8);
    chk("t1_pop_cnt", o_pop_cnt, 8);
    chk("t1_pop_span", o_pop_last - o_pop_first + 1, 8);
    chk("t1_first_latency", o_pop_first, 2);
    chk("t1_beat_end", {29'd0, bus.beat_cnt}, 32'd0);
    chk("t1_drained", exp_q.size(), 0);

    // Backpressure then release
    drive_edge();
    bus.m_ready = 1'b0;
    fifo_write(8'h10, 8);
    expect_beats(8'h10, 8, 0);
    observe(5);
    chk("t2_ren_cnt", o_ren_cnt, 2);
    chk("t2_occ", {30'd0, bus.occupancy}, 32'd2);
    chk("t2_data", {24'd0, bus.m_data}, 32'h10);
    chk("t2_ren_off", {31'd0, bus.fifo_ren}, 32'd0);
    drive_edge();
    bus.m_ready = 1'b1;
    observe(10);
    chk("t2_pop_cnt", o_pop_cnt, 8);
    chk("t2_pop_span", o_pop_last - o_pop_first + 1, 8);
    chk("t2_drained", exp_q.size(), 0);

    // Trickle with toggling ready
    for (int i = 0; i < 24; i++) begin
      drive_edge();
      if ((i % 3) == 0) begin
        fifo_write(8'h30 + 8'(i / 3), 1);
        expect_beats(8'h30 + 8'(i / 3), 1, i / 3);
      end
      bus.m_ready = ((i % 2) == 0);
    end
    drive_edge();
    bus.m_ready = 1'b1;
    repeat (6) drive_edge();
    chk("t3_drained", exp_q.size(), 0);
    chk("t3_occ", {30'd0, bus.occupancy}, 32'd0);

    // Flush with two buffered words mid-packet
    bus.m_ready = 1'b0;
    fifo_write(8'h40, 8);
    expect_beats(8'h40, 2, 0);
    repeat (4) drive_edge();
    bus.m_ready = 1'b1;
    drive_edge();
    drive_edge();
    bus.m_ready = 1'b0;
    chk("t4_pre_occ", {30'd0, bus.occupancy}, 32'd2);
    chk("t4_pre_beat", {29'd0, bus.beat_cnt}, 32'd2);
    chk("t4_pre_data", {24'd0, bus.m_data}, 32'h42);
    flush = 1'b1;
    @(negedge clk);
    chk("t4_ren_in_flush", {31'd0, bus.fifo_ren}, 32'd0);
    drive_edge();
    flush = 1'b0;
    chk("t4_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("t4_beat", {29'd0, bus.beat_cnt}, 32'd0);
    chk("t4_occ", {30'd0, bus.occupancy}, 32'd0);
    expect_beats(8'h44, 4, 0);
    bus.m_ready = 1'b1;
    repeat (8) drive_edge();
    chk("t4_drained", exp_q.size(), 0);

    // Asynchronous reset mid-packet
    bus.m_ready = 1'b0;
    fifo_write(8'h50, 4);
    expect_beats(8'h50, 1, 0);
    repeat (4) drive_edge();
    bus.m_ready = 1'b1;
    drive_edge();
    bus.m_ready = 1'b0;
    chk("t5_pre_beat", {29'd0, bus.beat_cnt}, 32'd1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_occ", {30'd0, bus.occupancy}, 32'd0);
    chk("t5_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("t5_beat", {29'd0, bus.beat_cnt}, 32'd0);
    chk("t5_data", {24'd0, bus.m_data}, 32'd0);
    chk("t5_last", {31'd0, bus.m_last}, 32'd0);
    chk("t5_ren", {31'd0, bus.fifo_ren}, 32'd0);
    drive_edge();
    drive_edge();
    reset_n = 1'b1;
    drive_edge();
    bus.m_ready = 1'b1;
    fifo_write(8'h60, 4);
    expect_beats(8'h60, 4, 0);
    observe(8);
    chk("t5_first_latency", o_pop_first, 2);
    chk("t5_pop_cnt", o_pop_cnt, 4);
    chk("t5_drained", exp_q.size(), 0);

    // FIFO stays empty
    observe(10);
    chk("t6_ren_cnt", o_ren_cnt, 0);
    chk("t6_pop_cnt", o_pop_cnt, 0);
    chk("t6_valid", {31'd0, bus.m_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
